// File: rtl/rr_arbiter_8.sv
// rtl/rr_arbiter_8.sv - 8-way round-robin arbiter with registered one-hot grant
//
// Shares one downstream resource among NREQ requesters. The winner index is
// registered and decoded into a one-hot grant; the grant is held until the
// owner pulses done or drops its request, and priority rotates past the most
// recent owner.
//
// Optional feature macro: ARB_TIMEOUT_EN (adds a hold counter that revokes a
// grant held for MAX_HOLD cycles and pulses timeout).
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   req         in   [NREQ-1:0] request lines
//   done        in   release strobe from the current owner (BUSY only)
//   grant       out  [NREQ-1:0] registered one-hot grant, zero when idle
//   grant_idx   out  [IDXW-1:0] index of the current owner
//   grant_valid out  high while a grant is held
//   timeout     out  one-cycle pulse when a grant is forcibly revoked

module rr_arbiter_8 #(
    parameter int NREQ     = 8,
    parameter int IDXW     = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            done,
    output logic [NREQ-1:0] grant,
    output logic [IDXW-1:0] grant_idx,
    output logic            grant_valid,
    output logic            timeout
);

    if (NREQ != 8 || IDXW != 3 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_params
        $error("rr_arbiter_8: illegal parameter combination");
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] last_q, last_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [IDXW-1:0] grant_idx_q, grant_idx_d;
    logic            grant_valid_q, grant_valid_d;

    // Rotating priority search: scan last+1, last+2, ... wrapping naturally
    // through the IDXW-bit add; offset NREQ lands back on last itself.
    logic [IDXW-1:0] winner;
    logic [IDXW-1:0] cand;
    logic            found;

    always_comb begin
        winner = last_q;
        cand   = last_q;
        found  = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = last_q + IDXW'(k);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    // 3-to-8 decoder for the grant vector.
    logic [NREQ-1:0] winner_onehot;

    always_comb begin
        winner_onehot = '0;
        winner_onehot[winner] = 1'b1;
    end

    logic owner_release;
    assign owner_release = done || !req[grant_idx_q];

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_q, hold_d;
    logic       timeout_q, timeout_d;
`endif

    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        grant_d       = grant_q;
        grant_idx_d   = grant_idx_q;
        grant_valid_d = grant_valid_q;
`ifdef ARB_TIMEOUT_EN
        hold_d        = hold_q;
        timeout_d     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                grant_d       = '0;
                grant_idx_d   = '0;
                grant_valid_d = 1'b0;
                if (|req) begin
                    state_d       = ST_BUSY;
                    grant_d       = winner_onehot;
                    grant_idx_d   = winner;
                    grant_valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    hold_d        = 8'd0;
`endif
                end
            end
            ST_BUSY: begin
                if (owner_release) begin
                    state_d       = ST_IDLE;
                    last_d        = grant_idx_q;
                    grant_d       = '0;
                    grant_idx_d   = '0;
                    grant_valid_d = 1'b0;
                end
`ifdef ARB_TIMEOUT_EN
                // A release in the same cycle wins over the timeout, so the
                // pulse only marks a genuine revocation.
                else if (hold_q == 8'(MAX_HOLD)) begin
                    state_d       = ST_IDLE;
                    last_d        = grant_idx_q;
                    grant_d       = '0;
                    grant_idx_d   = '0;
                    grant_valid_d = 1'b0;
                    timeout_d     = 1'b1;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            last_q        <= IDXW'(NREQ - 1);
            grant_q       <= '0;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            grant_q       <= grant_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = grant_idx_q;
    assign grant_valid = grant_valid_q;

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule
